norm_block_sched: RTL and testbench
===================================

NORM_BLOCK_SCHED -- requirements
Module: norm_block_sched

Interface
REQ-001 SHALL have parameter LINE, default 40, meaning cells per image row.
REQ-002 SHALL have parameter ROWS, default 30, meaning cell rows per frame.
REQ-003 SHALL have parameter ADDR_W, default 6, meaning cell-RAM address width.
REQ-004 SHALL have parameter MAX_ADDR, default 42 (LINE+2), meaning cell-RAM ring depth.
REQ-005 SHALL have port clk, input, 1, meaning the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset, asynchronous and active-low.
REQ-007 SHALL have port cell_valid, input, 1, meaning a cell histogram is offered.
REQ-008 SHALL have port cell_ready, output, 1, meaning the scheduler accepts the cell this cycle.
REQ-009 SHALL have port wr_en, output, 1, meaning the cell RAM write strobe.
REQ-010 SHALL have port wr_addr, output, ADDR_W, meaning the cell RAM write address.
REQ-011 SHALL have port rd_addr, output, ADDR_W, meaning the cell RAM read address.
REQ-012 SHALL have port rd_sel, output, 2, meaning block cell index: 0=current, 1=left, 2=up, 3=up-left.
REQ-013 SHALL have port bin_idx, output, 4, meaning the bin index 0..8 muxed into the divider.
REQ-014 SHALL have port sum_clr, output, 1, meaning load block sum with b_sum+epsilon.
REQ-015 SHALL have port sum_acc, output, 1, meaning accumulate b_sum into the block sum.
REQ-016 SHALL have port div_start, output, 1, meaning the divider operand is valid this cycle.
REQ-017 SHALL have port blk_done, output, 1, meaning one-cycle pulse when a block's 36 divides are issued.
REQ-018 SHALL have port frame_done, output, 1, meaning one-cycle pulse after the last block of the frame.

Function
REQ-019 SHALL accept a cell on the cycle where cell_valid=1 and cell_ready=1; wr_en SHALL equal that accept combinationally, with wr_addr the current write pointer.
REQ-020 SHALL drive cell_ready=1 only in state IDLE.
REQ-021 SHALL advance wr_addr on each accept, wrapping MAX_ADDR-1 -> 0.
REQ-022 SHALL keep col (0..LINE-1) and row (0..ROWS-1) counters advancing on accept; col wraps and increments row.
REQ-023 SHALL, on accept with col>=1 and row>=1, enter SUM next cycle; otherwise stay IDLE.
REQ-024 SHALL compute block addresses a=accepted address, a-1, a-LINE, a-LINE-1, all modulo MAX_ADDR (e.g. a=0 -> 41, 2, 1).
REQ-025 SUM (4 cycles): rd_sel 0,1,2,3 in order; sum_clr=1 on first cycle, sum_acc=1 on the other three.
REQ-026 GAP (1 cycle): covers RAM read latency; no strobes asserted.
REQ-027 DIV (36 cycles): rd_sel steps 0..3, each held 9 cycles with bin_idx 0..8; div_start=1 every cycle.
REQ-028 SHALL pulse blk_done on the last DIV cycle and return to IDLE next cycle; busy period = 41 cycles.
REQ-029 SHALL pulse frame_done together with blk_done of the block for row ROWS-1, col LINE-1, then clear col, row and wr_addr to 0.
REQ-030 Cells offered while not IDLE SHALL stall (cell_valid held by source); no cell lost or duplicated.
REQ-031 sum_clr, sum_acc, div_start and blk_done SHALL be mutually consistent: at most one of sum_clr/sum_acc/div_start high per cycle.

Reset
REQ-032 While rst=0: state IDLE, col=row=0, wr_addr=0, rd_addr=0, rd_sel=0, bin_idx=0, all strobes 0, cell_ready=0.
REQ-033 Reset asserted mid-SUM or mid-DIV SHALL abort immediately; no blk_done or frame_done is emitted for the aborted block.
REQ-034 cell_ready SHALL rise on the first clock edge after rst deasserts.

Configuration
REQ-035 With macro NORM_SCHED_STALL_CNT_EN defined, SHALL add output stall_cnt (16 bits) counting cycles with cell_valid=1 and cell_ready=0, saturating at 16'hFFFF, cleared by reset and on the cycle after frame_done.
REQ-036 Without NORM_SCHED_STALL_CNT_EN, port stall_cnt and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-037 First row: 40 back-to-back cells -> 40 wr_en, wr_addr 0..39, no SUM entry, cell_ready constant 1.
REQ-038 Cell 41 (row 1, col 0) then cell 42 (row 1, col 1, addr 41) -> rd_addr 41,40,1,0 in SUM; 36 div_start; blk_done 41 cycles after accept.
REQ-039 Write pointer wrap: accept at wr_addr=0 in row>=1 col>=1 -> rd_addr sequence 0,41,2,1.
REQ-040 cell_valid held during DIV -> cell_ready=0 until IDLE; cell accepted exactly once on IDLE; stall_cnt (if enabled) = stalled cycles.
REQ-041 Full 1200-cell frame -> 39*29=1131 blk_done pulses, one frame_done, then wr_addr=0, col=row=0.
REQ-042 rst low during DIV cycle 10 -> all outputs at reset values, no blk_done; next frame starts at wr_addr 0.

Source files
------------

// File: rtl/norm_block_sched.sv
// norm_block_sched -- block-normalisation scheduler for a cell-histogram stream.
//
// Accepts one cell histogram at a time and writes it into a ring-buffered cell
// RAM. Once the cell completes a 2x2 block (col>=1, row>=1), the scheduler
// reads the four block cells twice. The first pass builds the block sum
// (SUM). After one cycle of RAM read latency (GAP), the second pass issues
// 36 divides, one per bin per cell (DIV).
//
// Optional feature: define NORM_SCHED_STALL_CNT_EN to add the stall_cnt
// output. It counts cycles where a cell is offered but not accepted.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   cell_valid  a cell histogram is offered
//   cell_ready  cell accepted this cycle (IDLE only)
//   wr_en       cell RAM write strobe (== accept)
//   wr_addr     cell RAM write address (ring pointer)
//   rd_addr     cell RAM read address for the selected block cell
//   rd_sel      block cell index: 0=current 1=left 2=up 3=up-left
//   bin_idx     bin index 0..8 fed to the divider mux
//   sum_clr     load block sum with b_sum+epsilon
//   sum_acc     accumulate b_sum into block sum
//   div_start   divider operand valid
//   blk_done    pulse on the last divide of a block
//   frame_done  pulse with blk_done of the final block in the frame
//   stall_cnt   (optional) saturating count of stalled offers
module norm_block_sched #(
  parameter int LINE     = 40,
  parameter int ROWS     = 30,
  parameter int ADDR_W   = 6,
  parameter int MAX_ADDR = LINE + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cell_valid,
  output logic              cell_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        rd_sel,
  output logic [3:0]        bin_idx,
  output logic              sum_clr,
  output logic              sum_acc,
  output logic              div_start,
  output logic              blk_done,
  output logic              frame_done
`ifdef NORM_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int COL_W = (LINE > 1) ? $clog2(LINE) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    GAP  = 2'd2,
    DIV  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              run_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] base_q;
  logic              last_q;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        bin_q, bin_d;
  logic              accept;

  logic [ADDR_W-1:0] addr_left, addr_up, addr_ul;

  // Next-state and strobe logic
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    bin_d      = bin_q;
    sum_clr    = 1'b0;
    sum_acc    = 1'b0;
    div_start  = 1'b0;
    blk_done   = 1'b0;
    // run_q holds cell_ready low until the first edge after reset release
    cell_ready = run_q && (state_q == IDLE);
    accept     = cell_valid && cell_ready;
    wr_en      = accept;
    wr_addr    = wr_ptr_q;

    case (state_q)
      IDLE: begin
        sel_d = 2'd0;
        bin_d = 4'd0;
        if (accept && (col_q != '0) && (row_q != '0))
          state_d = SUM;
      end
      SUM: begin
        sum_clr = (sel_q == 2'd0);
        sum_acc = (sel_q != 2'd0);
        if (sel_q == 2'd3) begin
          sel_d   = 2'd0;
          state_d = GAP;
        end else begin
          sel_d = sel_q + 2'd1;
        end
      end
      GAP: begin
        sel_d   = 2'd0;
        bin_d   = 4'd0;
        state_d = DIV;
      end
      DIV: begin
        div_start = 1'b1;
        if (bin_q == 4'd8) begin
          bin_d = 4'd0;
          if (sel_q == 2'd3) begin
            sel_d    = 2'd0;
            blk_done = 1'b1;
            state_d  = IDLE;
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end else begin
          bin_d = bin_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    frame_done = blk_done && last_q;
  end

  // Block neighbour addresses, modulo the ring depth
  always_comb begin
    addr_left = (base_q == '0) ? ADDR_W'(MAX_ADDR - 1) : base_q - ADDR_W'(1);
    addr_up   = (base_q >= ADDR_W'(LINE)) ? base_q - ADDR_W'(LINE)
                                          : base_q + ADDR_W'(MAX_ADDR - LINE);
    addr_ul   = (base_q >= ADDR_W'(LINE + 1)) ? base_q - ADDR_W'(LINE + 1)
                                              : base_q + ADDR_W'(MAX_ADDR - LINE - 1);
  end

  // Read side is parked at zero outside SUM/DIV
  always_comb begin
    rd_sel  = 2'd0;
    bin_idx = 4'd0;
    rd_addr = '0;
    if (state_q == SUM || state_q == DIV) begin
      rd_sel = sel_q;
      case (sel_q)
        2'd0:    rd_addr = base_q;
        2'd1:    rd_addr = addr_left;
        2'd2:    rd_addr = addr_up;
        default: rd_addr = addr_ul;
      endcase
    end
    if (state_q == DIV)
      bin_idx = bin_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      wr_ptr_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      base_q   <= '0;
      last_q   <= 1'b0;
      sel_q    <= 2'd0;
      bin_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      sel_q   <= sel_d;
      bin_q   <= bin_d;
      if (accept) begin
        wr_ptr_q <= (wr_ptr_q == ADDR_W'(MAX_ADDR - 1)) ? '0 : wr_ptr_q + ADDR_W'(1);
        base_q   <= wr_ptr_q;
        last_q   <= (col_q == COL_W'(LINE - 1)) && (row_q == ROW_W'(ROWS - 1));
        if (col_q == COL_W'(LINE - 1)) begin
          col_q <= '0;
          row_q <= (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
      // End of frame realigns the ring to address 0 for the next frame
      if (frame_done) begin
        wr_ptr_q <= '0;
        col_q    <= '0;
        row_q    <= '0;
      end
    end
  end

`ifdef NORM_SCHED_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (frame_done)
      stall_cnt <= '0;
    else if (cell_valid && !cell_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_norm_block_sched.sv
// Testbench for norm_block_sched: randomized cell offers checked every cycle
// against a cycle-count reference model (cycles since accept -> expected
// strobes). Covers the reset state, the first row, a full frame, ring wrap
// and a reset abort during DIV.
module tb_norm_block_sched;
  localparam int LINE = 40;
  localparam int ROWS = 30;
  localparam int MAXA = 42;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cell_valid = 1'b0;
  logic       cell_ready, wr_en, sum_clr, sum_acc, div_start, blk_done, frame_done;
  logic [5:0] wr_addr, rd_addr;
  logic [1:0] rd_sel;
  logic [3:0] bin_idx;
`ifdef NORM_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  norm_block_sched #(.LINE(LINE), .ROWS(ROWS), .ADDR_W(6), .MAX_ADDR(MAXA)) dut (
    .clk(clk), .rst(rst), .cell_valid(cell_valid), .cell_ready(cell_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr), .rd_sel(rd_sel),
    .bin_idx(bin_idx), .sum_clr(sum_clr), .sum_acc(sum_acc),
    .div_start(div_start), .blk_done(blk_done), .frame_done(frame_done)
`ifdef NORM_SCHED_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int unsigned n;        // cells accepted so far in this frame
  int unsigned k;        // cycles since the block-opening accept, 0 = idle
  int unsigned blk_a;    // address of the cell that opened the block
  bit          blk_last;
  bit          started;
  int unsigned stall_m;
  int unsigned frames_m;
  int unsigned blk_dut, frm_dut;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; k = 0; blk_a = 0; blk_last = 0; started = 0; stall_m = 0;
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_ready"}, 32'(cell_ready), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    chk({tag, "_rd_sel"}, 32'(rd_sel), 0);
    chk({tag, "_bin"}, 32'(bin_idx), 0);
    chk({tag, "_strobes"}, {27'd0, sum_clr, sum_acc, div_start, blk_done, frame_done}, 0);
`ifdef NORM_SCHED_STALL_CNT_EN
    chk({tag, "_stall"}, 32'(stall_cnt), 0);
`endif
  endtask

  function automatic int unsigned cell_off(input int unsigned sel);
    case (sel)
      0: return 0;
      1: return 1;
      2: return LINE;
      default: return LINE + 1;
    endcase
  endfunction

  // One clock cycle: drive, check all outputs, advance the model
  task automatic step(input logic v);
    logic e_ready, e_acc, e_clr, e_sacc, e_div, e_blk, e_frm;
    int unsigned e_sel, e_bin, e_rd, j, col, row;
    @(posedge clk); #1;
    cell_valid = v;
    #2;
    e_ready = started && (k == 0);
    e_acc   = v && e_ready;
    e_sel = 0; e_bin = 0; e_rd = 0; e_clr = 0; e_sacc = 0; e_div = 0;
    if (k >= 1 && k <= 4) begin
      e_sel  = k - 1;
      e_clr  = (k == 1);
      e_sacc = (k > 1);
    end else if (k >= 6) begin
      j     = k - 6;
      e_sel = j / 9;
      e_bin = j % 9;
      e_div = 1;
    end
    if (k >= 1 && k != 5) e_rd = (blk_a + MAXA - cell_off(e_sel)) % MAXA;
    e_blk = (k == 41);
    e_frm = e_blk && blk_last;

    chk("cell_ready", 32'(cell_ready), 32'(e_ready));
    chk("wr_en", 32'(wr_en), 32'(e_acc));
    chk("wr_addr", 32'(wr_addr), n % MAXA);
    chk("rd_addr", 32'(rd_addr), e_rd);
    chk("rd_sel", 32'(rd_sel), e_sel);
    chk("bin_idx", 32'(bin_idx), e_bin);
    chk("sum_clr", 32'(sum_clr), 32'(e_clr));
    chk("sum_acc", 32'(sum_acc), 32'(e_sacc));
    chk("div_start", 32'(div_start), 32'(e_div));
    chk("blk_done", 32'(blk_done), 32'(e_blk));
    chk("frame_done", 32'(frame_done), 32'(e_frm));
`ifdef NORM_SCHED_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), stall_m);
`endif
    if (blk_done === 1'b1) blk_dut++;
    if (frame_done === 1'b1) frm_dut++;

    if (v && !e_ready && stall_m != 65535) stall_m++;
    if (e_frm) stall_m = 0;
    if (e_blk) begin
      k = 0;
      if (blk_last) begin
        n = 0;
        frames_m++;
      end
    end else if (k > 0) begin
      k++;
    end
    if (e_acc) begin
      col      = n % LINE;
      row      = n / LINE;
      blk_a    = n % MAXA;
      blk_last = (n == LINE * ROWS - 1);
      if (col >= 1 && row >= 1) k = 1;
      n++;
    end
  endtask

  initial begin
    int unsigned guard;
    model_reset();
    frames_m = 0; blk_dut = 0; frm_dut = 0;

    // Held in reset with a cell offered: nothing may be accepted
    rst = 1'b0;
    cell_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #3;
      check_rst("reset");
    end
    @(posedge clk); #1;
    cell_valid = 1'b0;
    rst = 1'b1;
    started = 1;

    // First row back-to-back, then random offers until the frame completes
    repeat (LINE) step(1'b1);
    guard = 0;
    while (frames_m == 0 && guard < 80000) begin
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      guard++;
    end
    chk("frame_reached", 32'(frames_m), 1);
    chk("blk_done_count", blk_dut, (LINE - 1) * (ROWS - 1));
    chk("frame_done_count", frm_dut, 1);
    repeat (3) step(1'b0);

    // Second frame: abort with reset in the middle of a DIV
    guard = 0;
    while (k != 15 && guard < 5000) begin
      step(($urandom_range(0, 1) != 0) ? 1'b1 : 1'b0);
      guard++;
    end
    chk("abort_reached", 32'(k), 15);
    @(posedge clk); #1;
    rst = 1'b0;
    cell_valid = 1'b1;
    #2;
    check_rst("abort");
    repeat (2) begin
      @(posedge clk); #3;
      check_rst("abort_hold");
    end
    @(posedge clk); #1;
    cell_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    started = 1;

    // Restart from address 0, including the ring wrap block at address 0
    guard = 0;
    while (n < 100 && guard < 10000) begin
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      guard++;
    end
    chk("restart_cells", n, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
